ex_case_decode: RTL and testbench

Registered, case-decoded byte-processing unit. Each clock it decodes an 8-bit address into an operation selector and an operation argument, applies that operation to a 10-bit input word, and presents the 8-bit result with a data-valid strobe one cycle later. It sits between a simple address/data stimulus source and downstream byte consumers. It is a single-cycle datapath with no internal state beyond its output registers.

---
 rtl/ex_case_decode.sv | 102 ++++++++++
 tb/tb_ex_case_decode.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ex_case_decode.sv
// Registered byte-processing unit: decodes i_addr into an op/argument pair,
// applies the op to i_data and registers the result with a valid strobe.
module ex_case_decode (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic [9:0] i_data,
    input  logic [7:0] i_addr,
    output logic       o_dv,
    output logic [7:0] o_data
);

    typedef enum logic [3:0] {
        OP_PASS  = 4'h0,
        OP_NOT   = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_XOR   = 4'h6,
        OP_ROL   = 4'h7,
        OP_ROR   = 4'h8,
        OP_SHL   = 4'h9,
        OP_SHR   = 4'hA,
        OP_REV   = 4'hB,
        OP_SWAP  = 4'hC,
        OP_POP   = 4'hD,
        OP_SATAD = 4'hE,
        OP_HIGH  = 4'hF
    } op_e;

    op_e        op;
    logic [3:0] k;
    logic [2:0] s;
    logic [7:0] x;
    logic [7:0] kk;
    logic       in_valid;

    assign op       = op_e'(i_addr[7:4]);
    assign k        = i_addr[3:0];
    assign s        = i_addr[2:0];
    assign x        = i_data[7:0];
    assign kk       = {k, k};
    assign in_valid = (i_addr != 8'h00);

    logic [7:0]  result;
    logic [15:0] rot;
    logic [8:0]  sat_sum;
    logic [3:0]  pop;
    logic [7:0]  rev;

    // Rotations shift a doubled copy of x so the wrapped bits fall into place.
    always_comb begin
        result  = 8'h00;
        rot     = 16'h0000;
        sat_sum = {1'b0, x} + {1'b0, k, 4'h0};
        pop     = 4'h0;
        rev     = 8'h00;
        for (int i = 0; i < 10; i++) begin
            pop = pop + {3'b000, i_data[i]};
        end
        for (int i = 0; i < 8; i++) begin
            rev[i] = x[7-i];
        end
        case (op)
            OP_PASS:  result = x;
            OP_NOT:   result = ~x;
            OP_ADD:   result = x + {4'h0, k};
            OP_SUB:   result = x - {4'h0, k};
            OP_AND:   result = x & kk;
            OP_OR:    result = x | kk;
            OP_XOR:   result = x ^ kk;
            OP_ROL: begin
                rot    = {x, x} << s;
                result = rot[15:8];
            end
            OP_ROR: begin
                rot    = {x, x} >> s;
                result = rot[7:0];
            end
            OP_SHL:   result = x << s;
            OP_SHR:   result = x >> s;
            OP_REV:   result = rev;
            OP_SWAP:  result = {x[3:0], x[7:4]};
            OP_POP:   result = {4'h0, pop};
            OP_SATAD: result = sat_sum[8] ? 8'hFF : sat_sum[7:0];
            OP_HIGH:  result = i_data[9:2];
            default:  result = 8'h00;
        endcase
    end

    // o_data is held at zero whenever no result is being presented.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            o_dv   <= 1'b0;
            o_data <= 8'h00;
        end else begin
            o_dv   <= in_valid;
            o_data <= in_valid ? result : 8'h00;
        end
    end

endmodule

// File: tb/tb_ex_case_decode.sv
// Directed bench for ex_case_decode: reset, idle/valid, per-op vectors,
// upper-bit handling, full stream sweep and a mid-stream reset.
module tb_ex_case_decode;

    logic       tb_sclk;
    logic       rst_n;
    logic [9:0] i_data;
    logic [7:0] i_addr;
    logic       o_dv;
    logic [7:0] o_data;

    int n_checks;
    int n_fail;

    ex_case_decode dut (
        .sclk   (tb_sclk),
        .rst_n  (rst_n),
        .i_data (i_data),
        .i_addr (i_addr),
        .o_dv   (o_dv),
        .o_data (o_data)
    );

    initial tb_sclk = 1'b0;
    always #5 tb_sclk = ~tb_sclk;

    // Reference result for a valid input, written arithmetically.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [9:0] d);
        int x, k, s, r;
        x = int'(d[7:0]);
        k = int'(a[3:0]);
        s = k % 8;
        r = 0;
        case (int'(a[7:4]))
            0:  r = x;
            1:  r = 255 - x;
            2:  r = (x + k) % 256;
            3:  r = (x - k + 256) % 256;
            4:  r = x & (k * 17);
            5:  r = x | (k * 17);
            6:  r = x ^ (k * 17);
            7:  r = ((x << s) | (x >> (8 - s))) & 255;
            8:  r = ((x >> s) | (x << (8 - s))) & 255;
            9:  r = (x << s) & 255;
            10: r = x >> s;
            11: for (int i = 0; i < 8; i++) if (d[i]) r = r + (1 << (7 - i));
            12: r = ((x % 16) * 16) + (x / 16);
            13: for (int i = 0; i < 10; i++) if (d[i]) r = r + 1;
            14: r = (x + k * 16 > 255) ? 255 : x + k * 16;
            15: r = int'(d) / 4;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    task automatic step();
        @(posedge tb_sclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        i_addr = 8'h05;
        i_data = 10'h005;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if (o_dv !== 1'b0 || o_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got dv=%b data=%h want dv=0 data=00", c, o_dv, o_data);
            end
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (o_dv !== 1'b1 || o_data !== 8'h05) begin
            n_fail++;
            $display("FAIL reset_release got dv=%b data=%h want dv=1 data=05", o_dv, o_data);
        end
    endtask

    task automatic test_idle_valid();
        i_addr = 8'h00;
        i_data = 10'h3A7;
        step();
        n_checks++;
        if (o_dv !== 1'b0 || o_data !== 8'h00) begin
            n_fail++;
            $display("FAIL idle got dv=%b data=%h want dv=0 data=00", o_dv, o_data);
        end
        i_addr = 8'h05;
        i_data = 10'h005;
        step();
        n_checks++;
        if (o_dv !== 1'b1 || o_data !== 8'h05) begin
            n_fail++;
            $display("FAIL valid_after_idle got dv=%b data=%h want dv=1 data=05", o_dv, o_data);
        end
    endtask

    task automatic test_ops();
        logic [7:0] vin [9]  = '{8'h1A, 8'h23, 8'h3F, 8'h73, 8'hB1, 8'hC5, 8'hD7, 8'hE8, 8'hFF};
        logic [7:0] vexp [9] = '{8'hE5, 8'h26, 8'h30, 8'h9B, 8'h8D, 8'h5C, 8'h06, 8'hFF, 8'h3F};
        for (int i = 0; i < 9; i++) begin
            i_addr = vin[i];
            i_data = {2'b00, vin[i]};
            step();
            n_checks++;
            if (o_dv !== 1'b1 || o_data !== vexp[i]) begin
                n_fail++;
                $display("FAIL op_%h got dv=%b data=%h want dv=1 data=%h", vin[i], o_dv, o_data, vexp[i]);
            end
        end
    endtask

    task automatic test_upper_bits();
        logic [7:0] a [3] = '{8'hF0, 8'hD0, 8'h10};
        logic [9:0] d [3] = '{10'h3FF, 10'h300, 10'h3FF};
        logic [7:0] e [3] = '{8'hFF, 8'h02, 8'h00};
        for (int i = 0; i < 3; i++) begin
            i_addr = a[i];
            i_data = d[i];
            step();
            n_checks++;
            if (o_dv !== 1'b1 || o_data !== e[i]) begin
                n_fail++;
                $display("FAIL upper_%h_%h got dv=%b data=%h want dv=1 data=%h", a[i], d[i], o_dv, o_data, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        logic       exp_v;
        int         dv_run;
        dv_run = 0;
        for (int i = 0; i <= 256; i++) begin
            i_addr = (i == 256) ? 8'h00 : 8'(i);
            i_data = {2'b00, i_addr};
            exp_v  = (i_addr != 8'h00);
            exp_d  = exp_v ? model(i_addr, i_data) : 8'h00;
            step();
            n_checks++;
            if (o_dv !== exp_v || o_data !== exp_d) begin
                n_fail++;
                $display("FAIL sweep_%0d got dv=%b data=%h want dv=%b data=%h", i, o_dv, o_data, exp_v, exp_d);
            end
            if (o_dv === 1'b1) dv_run++;
        end
        n_checks++;
        if (dv_run != 255) begin
            n_fail++;
            $display("FAIL sweep_dv_count got %0d want 255", dv_run);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [7:0] exp_d;
        for (int i = 8'h60; i < 8'h90; i++) begin
            i_addr = 8'(i);
            i_data = {2'b01, 8'(i)};
            rst_n  = (i == 8'h78) ? 1'b0 : 1'b1;
            exp_d  = (rst_n == 1'b0) ? 8'h00 : model(i_addr, i_data);
            step();
            n_checks++;
            if (o_dv !== rst_n || o_data !== exp_d) begin
                n_fail++;
                $display("FAIL midrst_%h got dv=%b data=%h want dv=%b data=%h", i_addr, o_dv, o_data, rst_n, exp_d);
            end
        end
        rst_n  = 1'b1;
        i_addr = 8'h00;
        i_data = 10'h000;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        i_addr   = 8'h00;
        i_data   = 10'h000;
        test_reset();
        test_idle_valid();
        test_ops();
        test_upper_bits();
        test_back_to_back();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
